// File: rtl/peripheral_wb_responder.sv
// Wishbone B3 responder backed by a word memory: classic cycles with optional
// wait states, incrementing bursts (linear / wrap-4/8/16), byte-lane writes and
// err termination for addresses beyond the memory.
module peripheral_wb_responder #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int unsigned IW = AW - 2;
  localparam int unsigned MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned SW = DW / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SINGLE = 2'd2;
  localparam logic [1:0] S_BURST  = 2'd3;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [DW-1:0] mem [MEM_WORDS];

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_d, err_d;
  logic [DW-1:0] dat_d;
  logic          mem_we_c;
  logic [IW-1:0] req_idx_c;
  logic [IW-1:0] nxt_idx_c;
  logic          unused_c;

  assign unused_c  = ^wb_adr_i[1:0];
  assign req_idx_c = wb_adr_i[AW-1:2];

  // Word index is backed by memory only below MEM_WORDS.
  function automatic logic in_range(input logic [IW-1:0] i);
    return 64'(i) < 64'(MEM_WORDS);
  endfunction

  // Read data for an index; out-of-range reads return zero.
  function automatic logic [DW-1:0] rd_word(input logic [IW-1:0] i);
    logic [DW-1:0] w;
    w = '0;
    if (in_range(i)) w = mem[i[MW-1:0]];
    return w;
  endfunction

  // Burst address sequence: linear increment or wrap within an aligned 4/8/16 block.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i, input logic [1:0] bte);
    logic [IW-1:0] n;
    n = i;
    case (bte)
      2'b00:   n      = i + IW'(1);
      2'b01:   n[1:0] = i[1:0] + 2'd1;
      2'b10:   n[2:0] = i[2:0] + 3'd1;
      default: n[3:0] = i[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  assign nxt_idx_c = next_idx(idx_q, bte_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    cti_d    = cti_q;
    bte_d    = bte_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = wb_dat_o;
    mem_we_c = 1'b0;
    if (!wb_cyc_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wb_stb_i) begin
            idx_d = req_idx_c;
            we_d  = wb_we_i;
            cti_d = wb_cti_i;
            bte_d = wb_bte_i;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              cnt_d   = WS_LOAD;
            end else begin
              state_d = (wb_cti_i == CTI_INCR) ? S_BURST : S_SINGLE;
              ack_d   = in_range(req_idx_c);
              err_d   = !in_range(req_idx_c);
              dat_d   = rd_word(req_idx_c);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = (cti_q == CTI_INCR) ? S_BURST : S_SINGLE;
            ack_d   = in_range(idx_q);
            err_d   = !in_range(idx_q);
            dat_d   = rd_word(idx_q);
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_SINGLE: begin
          state_d  = S_IDLE;
          mem_we_c = wb_ack_o & wb_stb_i & we_q;
        end
        S_BURST: begin
          if (wb_err_o) begin
            state_d = S_IDLE;
          end else if (wb_stb_i & wb_ack_o) begin
            mem_we_c = we_q;
            if (wb_cti_i == CTI_EOB) begin
              state_d = S_IDLE;
            end else begin
              idx_d = nxt_idx_c;
              ack_d = in_range(nxt_idx_c);
              err_d = !in_range(nxt_idx_c);
              dat_d = rd_word(nxt_idx_c);
            end
          end else begin
            ack_d = wb_ack_o;
            dat_d = rd_word(idx_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      we_q     <= 1'b0;
      cti_q    <= 3'b000;
      bte_q    <= 2'b00;
      cnt_q    <= 4'd0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      cti_q    <= cti_d;
      bte_q    <= bte_d;
      cnt_q    <= cnt_d;
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      wb_rty_o <= 1'b0;
      wb_dat_o <= dat_d;
    end
  end

  // Byte-lane memory write on a completed, acked write beat.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) begin
      for (int b = 0; b < SW; b++) begin
        if (wb_sel_i[b]) mem[idx_q[MW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/peripheral_wb_responder.md
# peripheral_wb_responder

Wishbone B3 slave (responder) with an internal word memory. It is the target end for the WishBone bus functional model and for initiators on the peripheral bus. It supports classic single cycles with configurable wait states and registered-feedback incrementing bursts (linear and wrap-4/8/16), byte-lane writes, and error termination for out-of-range addresses.

## Interface
Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width; only 32 is supported
- MEM_WORDS, 1024, memory depth in DW-bit words
- WAIT_STATES, 0, extra cycles inserted before the first ack/err of every cycle (0..15)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wb_adr_i  in  AW  byte address; word index = wb_adr_i[AW-1:2]
- wb_dat_i  in  DW  write data
- wb_sel_i  in  DW/8  byte-lane enables
- wb_we_i  in  1  1 = write, 0 = read
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; all other codes are treated as classic
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_dat_o  out  DW  read data
- wb_ack_o  out  1  normal termination
- wb_err_o  out  1  error termination
- wb_rty_o  out  1  always 0

## Operation
- FSM states: IDLE, WAIT, SINGLE, BURST.
- IDLE: when wb_cyc_i & wb_stb_i, latch the word index, we, cti and bte.
  - WAIT_STATES > 0: go to WAIT and load the counter with WAIT_STATES-1.
  - Otherwise go to SINGLE if the latched cti ≠ 010, or to BURST if it is 010.
- WAIT: decrement the counter. At 0, go to SINGLE or BURST as above.
- SINGLE: assert ack (or err) for exactly one cycle, then return to IDLE.
- BURST: ack is high every cycle.
  - A beat completes when wb_stb_i & wb_ack_o are both high.
  - On a completed beat, the internal index advances per the latched bte. Wrap-N increments the low log2(N) bits modulo N; the upper bits are held.
  - A cycle with ack high and stb low completes no beat and does not advance the index.
  - A completed beat with wb_cti_i = 111 is the last beat: ack drops the next cycle and the FSM goes to IDLE.
- Range check: index ≥ MEM_WORDS asserts wb_err_o instead of wb_ack_o.
  - No write is performed and wb_dat_o = 0.
  - A burst that reaches an out-of-range index terminates with err on that beat and returns to IDLE.
- Write: on a completed write beat, update only the lanes with wb_sel_i set, using wb_dat_i sampled in that cycle. wb_sel_i = 0 gives an ack with no change.
- Read: wb_dat_o holds mem[current index] in every cycle that ack is high; otherwise it holds its last value.
- wb_cyc_i low in any state: next state is IDLE, ack/err deassert the next cycle, and no write is performed in a cycle where cyc is low.
- Reset:
  - In any state: FSM → IDLE; wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o = 0; counter = 0.
  - Memory contents are not reset.

## Timing
- Classic: request sampled at cycle T; ack/err high in cycle T+1+WAIT_STATES only; IDLE at T+2+WAIT_STATES.
  - Back-to-back classic throughput: one transfer per 2+WAIT_STATES cycles.
- Burst: first ack at T+1+WAIT_STATES, then one beat per cycle while stb is held high.
  - An N-beat burst with stb continuously high takes N+1+WAIT_STATES cycles from T.
- ack and err are never high in the same cycle.
- ack/err are registered outputs; there is no combinational path from inputs to outputs.
- A write is visible to a read issued in the following bus cycle.

## Test plan
- Reset mid-burst: hold rst high for 1 cycle during BURST → next cycle all outputs are 0 and the FSM is IDLE. A following classic read of 0x10 acks at T+1 with the correct data.
- Classic, WAIT_STATES=0: write 0xDEADBEEF to 0x40 with sel=1111, then read 0x40 → ack one cycle at T+1 for each transfer, read data 0xDEADBEEF. Write 0x000000AA with sel=0001, then read → 0xDEADBEAA.
- WAIT_STATES=3: classic read of 0x8 → ack exactly at T+4, ack high for one cycle, err never high.
- Wrap4 burst: read starting at 0x0C (index 3), 4 beats, cti 010,010,010,111 → indices 3,0,1,2 returned on consecutive cycles; ack low on the cycle after the 111 beat.
- Linear burst with the master stalling stb low for 2 cycles mid-burst → no index advance while stalled; the returned sequence is contiguous.
- MEM_WORDS=1024:
  - Classic write to 0x1000 (index 1024) → err for one cycle, ack 0, memory unchanged.
  - Linear burst from index 1022 → acks at 1022 and 1023, err on the third beat, FSM in IDLE.
